// File: rtl/fas.sv
// Streaming frequency analyser: 32-tap symmetric FIR, a 16-point DFT over each frame of 16
// FIR outputs, and a peak-bin search over the resulting spectrum.
module fas (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid,
    input  logic [15:0] data,
    output logic        fir_valid,
    output logic [15:0] fir_d,
    output logic        fft_valid,
    output logic [31:0] fft_d0,
    output logic [31:0] fft_d1,
    output logic [31:0] fft_d2,
    output logic [31:0] fft_d3,
    output logic [31:0] fft_d4,
    output logic [31:0] fft_d5,
    output logic [31:0] fft_d6,
    output logic [31:0] fft_d7,
    output logic [31:0] fft_d8,
    output logic [31:0] fft_d9,
    output logic [31:0] fft_d10,
    output logic [31:0] fft_d11,
    output logic [31:0] fft_d12,
    output logic [31:0] fft_d13,
    output logic [31:0] fft_d14,
    output logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq
);
    localparam int TAPS = 32;
    localparam int NPT  = 16;

    // C00..C15 in 4.16; the set is symmetric, so C(31-i) = C(i)
    localparam logic signed [19:0] FirCoef [TAPS/2] = '{
        -20'sd75,   -20'sd143,  -20'sd260,  -20'sd300,
        -20'sd210,   20'sd13,    20'sd287,   20'sd661,
         20'sd1093,  20'sd1542,  20'sd2103,  20'sd2771,
         20'sd3398,  20'sd3917,  20'sd4267,  20'sd4415
    };

    // Drop 16 fractional bits, rounding toward zero.
    function automatic logic [15:0] trunc_q88(input logic signed [41:0] a);
        logic round_up;
        round_up = a[41] && (a[15:0] != 16'd0);
        return a[31:16] + {15'd0, round_up};
    endfunction

    function automatic logic signed [17:0] cos_tw(input logic [3:0] t);
        logic signed [17:0] c;
        unique case (t)
            4'd0:  c = 18'sd65536;
            4'd1:  c = 18'sd60547;
            4'd2:  c = 18'sd46341;
            4'd3:  c = 18'sd25080;
            4'd4:  c = 18'sd0;
            4'd5:  c = -18'sd25080;
            4'd6:  c = -18'sd46341;
            4'd7:  c = -18'sd60547;
            4'd8:  c = -18'sd65536;
            4'd9:  c = -18'sd60547;
            4'd10: c = -18'sd46341;
            4'd11: c = -18'sd25080;
            4'd12: c = 18'sd0;
            4'd13: c = 18'sd25080;
            4'd14: c = 18'sd46341;
            4'd15: c = 18'sd60547;
        endcase
        return c;
    endfunction

    // FIR
    logic signed [15:0] taps_q [TAPS-1];
    logic signed [15:0] win [TAPS];
    logic        [4:0]  fill_q;
    logic signed [16:0] pair;
    logic signed [41:0] fir_acc;

    always_comb begin
        win[0] = data;
        for (int i = 1; i < TAPS; i++) begin
            win[i] = taps_q[i-1];
        end
    end

    // Symmetric taps let each coefficient multiply a pre-added sample pair.
    always_comb begin
        fir_acc = '0;
        pair    = '0;
        for (int i = 0; i < TAPS/2; i++) begin
            pair    = 17'(win[i]) + 17'(win[TAPS-1-i]);
            fir_acc = fir_acc + 42'(pair) * 42'(FirCoef[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS-1; i++) begin
                taps_q[i] <= '0;
            end
            fill_q    <= '0;
            fir_valid <= 1'b0;
            fir_d     <= '0;
        end else begin
            fir_valid <= data_valid && (fill_q == 5'(TAPS-1));
            if (data_valid) begin
                for (int i = 0; i < TAPS-1; i++) begin
                    taps_q[i] <= win[i];
                end
                if (fill_q != 5'(TAPS-1)) begin
                    fill_q <= fill_q + 5'd1;
                end else begin
                    fir_d <= trunc_q88(fir_acc);
                end
            end
        end
    end

    // DFT: every FIR output is folded into all 16 bin accumulators as it arrives, so a
    // frame's result is ready the cycle after its last sample and the next frame starts clean.
    logic        [3:0]  m_q;
    logic        [3:0]  mk;
    logic signed [39:0] acc_re_q [NPT];
    logic signed [39:0] acc_im_q [NPT];
    logic signed [39:0] re_nxt [NPT];
    logic signed [39:0] im_nxt [NPT];
    logic        [31:0] fft_q [NPT];

    always_comb begin
        mk = '0;
        for (int k = 0; k < NPT; k++) begin
            mk        = m_q * 4'(k);
            re_nxt[k] = acc_re_q[k] + 40'($signed(fir_d)) * 40'(cos_tw(mk));
            // sin(t) = cos(t - 4 steps)
            im_nxt[k] = acc_im_q[k] - 40'($signed(fir_d)) * 40'(cos_tw(mk + 4'd12));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            fft_valid <= 1'b0;
            for (int k = 0; k < NPT; k++) begin
                acc_re_q[k] <= '0;
                acc_im_q[k] <= '0;
                fft_q[k]    <= '0;
            end
        end else begin
            fft_valid <= 1'b0;
            if (fir_valid) begin
                m_q       <= m_q + 4'd1;
                fft_valid <= (m_q == 4'(NPT-1));
                for (int k = 0; k < NPT; k++) begin
                    if (m_q == 4'(NPT-1)) begin
                        acc_re_q[k] <= '0;
                        acc_im_q[k] <= '0;
                        fft_q[k]    <= {trunc_q88(42'(re_nxt[k])), trunc_q88(42'(im_nxt[k]))};
                    end else begin
                        acc_re_q[k] <= re_nxt[k];
                        acc_im_q[k] <= im_nxt[k];
                    end
                end
            end
        end
    end

    // Peak search; strict compare keeps the lowest index on ties.
    logic signed [15:0] re_v, im_v;
    logic signed [31:0] re_sq, im_sq;
    logic        [32:0] cur_mag, best_mag;
    logic        [3:0]  best_k;

    always_comb begin
        re_v     = '0;
        im_v     = '0;
        re_sq    = '0;
        im_sq    = '0;
        cur_mag  = '0;
        best_mag = '0;
        best_k   = '0;
        for (int k = 0; k < NPT; k++) begin
            re_v    = fft_q[k][31:16];
            im_v    = fft_q[k][15:0];
            re_sq   = 32'(re_v) * 32'(re_v);
            im_sq   = 32'(im_v) * 32'(im_v);
            cur_mag = {1'b0, re_sq} + {1'b0, im_sq};
            if (k == 0 || cur_mag > best_mag) begin
                best_mag = cur_mag;
                best_k   = 4'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            freq <= '0;
        end else begin
            done <= fft_valid;
            if (fft_valid) begin
                freq <= best_k;
            end
        end
    end

    assign fft_d0  = fft_q[0];
    assign fft_d1  = fft_q[1];
    assign fft_d2  = fft_q[2];
    assign fft_d3  = fft_q[3];
    assign fft_d4  = fft_q[4];
    assign fft_d5  = fft_q[5];
    assign fft_d6  = fft_q[6];
    assign fft_d7  = fft_q[7];
    assign fft_d8  = fft_q[8];
    assign fft_d9  = fft_q[9];
    assign fft_d10 = fft_q[10];
    assign fft_d11 = fft_q[11];
    assign fft_d12 = fft_q[12];
    assign fft_d13 = fft_q[13];
    assign fft_d14 = fft_q[14];
    assign fft_d15 = fft_q[15];

endmodule

// File: tb/tb_fas.sv
// Bench for fas: directed and random streams checked against an arithmetic FIR and a
// floating-point DFT reference.
`timescale 1ns/1ps
module tb_fas;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid = 1'b0;
    logic [15:0] data = '0;
    logic        fir_valid, fft_valid, done;
    logic [15:0] fir_d;
    logic [31:0] fd [16];
    logic [3:0]  freq;

    int total = 0;
    int bad = 0;

    fas dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .fir_valid(fir_valid), .fir_d(fir_d), .fft_valid(fft_valid),
        .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
        .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
        .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
        .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
        .done(done), .freq(freq)
    );

    always #5 clk = ~clk;

    localparam real Pi = 3.14159265358979;
    int  coef_h [16] = '{-75, -143, -260, -300, -210, 13, 287, 661,
                         1093, 1542, 2103, 2771, 3398, 3917, 4267, 4415};
    int  hist [$];
    int  frame [$];
    real ideal_re [16];
    real ideal_im [16];
    bit  pend_fft = 0;
    bit  pend_done = 0;
    bit  freq_chk = 0;
    int  exp_freq = 0;
    int  tone_n = 0;

    function automatic int coef(input int i);
        return (i < 16) ? coef_h[i] : coef_h[31 - i];
    endfunction

    function automatic longint rnd(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_bin(input string tag, input int k, input logic [15:0] obs,
                             input real ideal);
        longint  e;
        shortint d;
        e = rnd(ideal);
        d = shortint'(longint'(obs) - e);
        total++;
        assert ((d >= -3 && d <= 3) === 1'b1) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d+-3", tag, k, $signed(obs), e);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".fir_valid"}, fir_valid, 0);
        check({tag, ".fir_d"}, fir_d, 0);
        check({tag, ".fft_valid"}, fft_valid, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".freq"}, freq, 0);
        for (int k = 0; k < 16; k++) check({tag, ".fft_d"}, fd[k], 0);
    endtask

    // Ideal DFT of the completed frame plus the expected peak bin, where it is unambiguous.
    task automatic frame_model();
        real mag, best, second;
        int  bk;
        bit  in_range;
        in_range = 1;
        for (int k = 0; k < 16; k++) begin
            ideal_re[k] = 0.0;
            ideal_im[k] = 0.0;
            for (int m = 0; m < 16; m++) begin
                ideal_re[k] += frame[m] * $cos(2.0 * Pi * m * k / 16.0);
                ideal_im[k] -= frame[m] * $sin(2.0 * Pi * m * k / 16.0);
            end
            if (ideal_re[k] > 32000.0 || ideal_re[k] < -32000.0 ||
                ideal_im[k] > 32000.0 || ideal_im[k] < -32000.0) in_range = 0;
        end
        // Real input: |X[k]| = |X[16-k]|, so only bins 0..8 decide the lowest-index winner.
        best = -1.0;
        bk = 0;
        for (int k = 0; k <= 8; k++) begin
            mag = ideal_re[k] * ideal_re[k] + ideal_im[k] * ideal_im[k];
            if (mag > best) begin
                best = mag;
                bk = k;
            end
        end
        second = 0.0;
        for (int k = 0; k <= 8; k++) begin
            mag = ideal_re[k] * ideal_re[k] + ideal_im[k] * ideal_im[k];
            if (k != bk && mag > second) second = mag;
        end
        exp_freq = bk;
        freq_chk = in_range && (best > 100.0) && (second < 0.7 * best);
    endtask

    task automatic cycle(input logic [15:0] s);
        bit     exp_fft, exp_done;
        longint y;
        data = s;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_fft = pend_fft;
        exp_done = pend_done;
        pend_done = exp_fft;
        pend_fft = 0;
        check("fft_valid", fft_valid, exp_fft);
        if (exp_fft) begin
            for (int k = 0; k < 16; k++) begin
                check_bin("fft_re", k, fd[k][31:16], ideal_re[k]);
                check_bin("fft_im", k, fd[k][15:0], ideal_im[k]);
            end
        end
        check("done", done, exp_done);
        if (exp_done && freq_chk) check("freq", freq, exp_freq);

        hist.push_front(int'($signed(s)));
        if (hist.size() > 32) void'(hist.pop_back());
        check("fir_valid", fir_valid, hist.size() == 32);
        if (hist.size() == 32) begin
            y = 0;
            for (int i = 0; i < 32; i++) y += longint'(coef(i)) * hist[i];
            y = y / 65536;  // integer division truncates toward zero
            check("fir_d", $signed(fir_d), y);
            frame.push_back(int'(y));
            if (frame.size() == 16) begin
                frame_model();
                frame.delete();
                pend_fft = 1;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        frame.delete();
        pend_fft = 0;
        pend_done = 0;
        freq_chk = 0;
    endtask

    function automatic logic [15:0] tone_sample();
        int v;
        v = int'(rnd(384.0 * $cos(2.0 * Pi * tone_n / 16.0)));
        v += int'($urandom_range(16, 0)) - 8;
        tone_n++;
        return 16'(v);
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        model_reset();

        // Fill with 31 zeros, then a unit impulse, then zeros
        for (int i = 0; i < 31; i++) cycle(16'h0000);
        cycle(16'h0100);
        for (int i = 0; i < 63; i++) cycle(16'h0000);

        // DC level of 1.0
        for (int i = 0; i < 96; i++) cycle(16'h0100);

        // Full-range random samples
        for (int i = 0; i < 320; i++) cycle(16'($urandom));

        // Bin-1 tone with small random noise, 64 frames
        for (int i = 0; i < 1024; i++) cycle(tone_sample());

        // Restart, then reset again in the middle of the third frame
        #3 rst = 1'b1;
        #1 check_zero("rst_a");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 70; i++) cycle(tone_sample());
        #3 rst = 1'b1;
        #1 check_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 check_zero("midrst_hold");
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 200; i++) cycle(tone_sample());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
